// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory handshake bundle for the multi-cycle core.
// master = core side, slave = memory side.
interface multicycle_datapath_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core: one shared ALU sequenced by a
// FETCH/DECODE/EXEC/MEM/WB FSM, external memories behind req/ready.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_datapath_if.master bus,
  output logic [XLEN-1:0]       pc_out,
  output logic                  retire,
  output logic                  halted
);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BR = 7'b1100011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [XLEN-1:0]   pc, a, b, imm, res, mdr;
  logic [31:0]       ir;
  logic [XLEN-1:0]   regs [NREGS];
  logic              imem_req, dmem_req;

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rs1, rs2, rd;
  logic              is_rtype, is_addi, is_lw, is_sw, is_br, legal;
  logic              rs1_ok, rs2_ok, rd_ok, taken;
  logic [XLEN-1:0]   imm_dec, alu_out;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] op, input logic sub,
                                            input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] sx, sy;
    sx = x;
    sy = y;
    case (op)
      3'b000:  alu_f = sub ? x - y : x + y;
      3'b111:  alu_f = x & y;
      3'b110:  alu_f = x | y;
      3'b100:  alu_f = x ^ y;
      3'b010:  alu_f = {{(XLEN-1){1'b0}}, (sx < sy)};
      default: alu_f = x + y;
    endcase
  endfunction

  // Instruction classification, legality (including register range) and immediate
  always_comb begin
    is_rtype = 1'b0;
    if (opcode == OP_R) begin
      if (funct7 == 7'b0000000)
        is_rtype = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                   (funct3 == 3'b100) || (funct3 == 3'b010);
      else if (funct7 == 7'b0100000)
        is_rtype = (funct3 == 3'b000);
    end
    is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
    is_lw   = (opcode == OP_LW)  && (funct3 == 3'b010);
    is_sw   = (opcode == OP_SW)  && (funct3 == 3'b010);
    is_br   = (opcode == OP_BR)  && ((funct3 == 3'b000) || (funct3 == 3'b001));
    rs1_ok  = 32'(rs1) < NREGS;
    rs2_ok  = 32'(rs2) < NREGS;
    rd_ok   = 32'(rd)  < NREGS;
    legal   = (is_rtype && rs1_ok && rs2_ok && rd_ok) ||
              ((is_addi || is_lw) && rs1_ok && rd_ok) ||
              ((is_sw || is_br) && rs1_ok && rs2_ok);
    if (opcode == OP_SW)
      imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    else if (opcode == OP_BR)
      imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else
      imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
  end

  // Shared ALU: register operands for R-type, immediate for addi and address generation
  always_comb begin
    if (is_rtype)
      alu_out = alu_f(funct3, funct7[5], a, b);
    else
      alu_out = alu_f(3'b000, 1'b0, a, imm);
    taken = is_br && ((funct3 == 3'b000) ? (a == b) : (a != b));
  end

  // State register; run keeps requests low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Next-state and handshake/retire outputs
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = run;
        if (run && bus.imem_ready) state_nxt = DECODE;
      end
      DECODE: state_nxt = legal ? EXEC : HALT;
      EXEC: begin
        if (is_br) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          if (is_sw) begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  // Datapath registers: IR, operand latches, ALU result, load data and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      imm <= '0;
      res <= '0;
      mdr <= '0;
    end else begin
      case (state)
        FETCH:  if (run && bus.imem_ready) ir <= bus.imem_rdata;
        DECODE: begin
          a   <= regs[rs1[IDX_W-1:0]];
          b   <= regs[rs2[IDX_W-1:0]];
          imm <= imm_dec;
        end
        EXEC: begin
          if (is_br) pc <= taken ? pc + imm : pc + XLEN'(4);
          else       res <= alu_out;
        end
        MEM: begin
          if (bus.dmem_ready) begin
            if (is_lw) mdr <= bus.dmem_rdata;
            else       pc  <= pc + XLEN'(4);
          end
        end
        WB:      pc <= pc + XLEN'(4);
        default: ;
      endcase
    end
  end

  // Register file write-back; x0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WB && rd != 5'd0) begin
      regs[rd[IDX_W-1:0]] <= is_lw ? mdr : res;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = imem_req ? pc : '0;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_req & is_sw;
  assign bus.dmem_addr  = res;
  assign bus.dmem_wdata = b;
  assign pc_out         = pc;
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle core datapath. It executes a RV32I subset over one shared ALU, sequenced by an internal FSM. Instruction and data memories sit outside the block behind req/ready handshakes, so it tolerates wait states. The register file, immediate sign-extension and branch resolution are all internal.

Parameters:
XLEN, 32, datapath and register width (≥ 32).
NREGS, 32, architectural register count; power of two, 2..32.
RESET_PC, 0, PC loaded on reset.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  effective address rs1 + imm
dmem_wdata  out  XLEN  store data (rs2)
dmem_ready  in  1  data access complete; dmem_rdata valid for loads
dmem_rdata  in  XLEN  load data
pc_out  out  XLEN  current pc
retire  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky; set on illegal instruction

Behaviour:
- Reset (async, rst_n = 0):
  - state = FETCH; pc = RESET_PC; all registers = 0.
  - All req, retire and halted outputs = 0; address and data outputs = 0.
  - Takes effect mid-handshake; the pending request drops immediately.
- Supported instructions:
  - R-type (0110011): add, sub, and, or, xor, slt.
  - addi (0010011, funct3 000).
  - lw (0000011), sw (0100011).
  - beq, bne (1100011).
  - Anything else is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req = 1 with imem_addr = pc, both held stable until imem_ready.
  - On the ready cycle, IR <= imem_rdata, then go to DECODE.
- DECODE:
  - A <= reg[rs1], B <= reg[rs2].
  - Imm formed and sign-extended to XLEN:
    - I: instr[31:20]
    - S: {instr[31:25], instr[11:7]}
    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - Illegal opcode/funct, or any rs1/rs2/rd ≥ NREGS: go to HALT with no architectural update.
- EXEC:
  - R-type/addi: compute result, go to WB.
  - lw/sw: compute address, go to MEM.
  - Branch: pc <= taken ? pc + imm : pc + 4; retire pulses; go to FETCH.
- MEM:
  - dmem_req = 1, with we, addr and wdata held stable until dmem_ready.
  - lw: latch rdata, go to WB.
  - sw: pc += 4, retire, go to FETCH.
- WB:
  - reg[rd] <= result unless rd = 0 (x0 reads 0, writes ignored).
  - pc += 4, retire, go to FETCH.
- HALT: halted = 1, no requests issued, pc frozen; only reset exits.
- Arithmetic wraps modulo 2^XLEN. slt is signed (result 1/0, zero-extended). Branch compare is the full XLEN.
- Latency with zero-wait memories (FETCH through retire, inclusive):
  - branch 3 cycles
  - R-type/addi 4
  - sw 4
  - lw 5
  - Each wait cycle on a memory adds 1.
- The next FETCH begins the cycle after retire.
- imem_ready or dmem_ready while the matching req is low is ignored.
- A write to rd in WB is visible to the next instruction's DECODE; no hazards exist.
- Addresses are passed through unaligned and unchecked; word access only.

Test Plan:
1. Reset/fetch: rst_n low, then high; zero-wait imem with addi x1,x0,5 at addr 0 -> first imem_addr = 0; retire 4 cycles after the first req; x1 = 5; pc_out = 4.
2. Sign-extension and wrap: addi x2,x0,-1 then add x3,x2,x2 -> x2 = 0xFFFFFFFF, x3 = 0xFFFFFFFE; addi x0,x0,7 leaves x0 = 0.
3. Memory waits: sw x1,8(x0) then lw x4,8(x0), with dmem_ready delayed 3 cycles -> dmem_addr = 8, wdata = 5, req held 4 cycles each; x4 = 5; lw retires 8 cycles after its fetch.
4. Branches: beq x1,x1,-8 at pc 0x10 -> next imem_addr = 0x08; bne x1,x1,+16 -> next imem_addr = 0x14; retire 3 cycles each.
5. Illegal: opcode 0x7F, or rd = 20 with NREGS = 16 -> halted = 1 from the cycle after DECODE; no further req; registers unchanged.
6. Async reset mid-MEM, with dmem_req high and dmem_ready never asserted -> dmem_req drops in the same cycle rst_n falls; after release, refetch at RESET_PC.
